// File: rtl/demux1to4_16bit_stream.sv
// rtl/demux1to4_16bit_stream.sv - registered 1-to-4 stream demux, one holding register per channel
// Optional per-channel delivered-word counters: define DEMUX1TO4_STATS_EN.

module demux1to4_16bit_stream #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   x,
    input  logic [1:0]         sel,
    input  logic               x_valid,
    output logic               x_ready,
    output logic [WIDTH-1:0]   y0,
    output logic [WIDTH-1:0]   y1,
    output logic [WIDTH-1:0]   y2,
    output logic [WIDTH-1:0]   y3,
    output logic [3:0]         y_valid,
    input  logic [3:0]         y_ready,
    output logic [4*CNT_W-1:0] stat_cnt
);

    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       valid_q;
    logic [3:0]       load;
    logic [3:0]       drain;
    logic             acc;

    // Ready depends only on the addressed channel, so a stalled channel
    // never blocks words bound for the others.
    assign x_ready = ~valid_q[sel] | y_ready[sel];
    assign acc     = x_valid & x_ready;
    assign drain   = valid_q & y_ready;

    always_comb begin
        load      = 4'b0000;
        load[sel] = acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i]  <= x;
                    valid_q[i] <= 1'b1;
                end else if (drain[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign y0      = data_q[0];
    assign y1      = data_q[1];
    assign y2      = data_q[2];
    assign y3      = data_q[3];
    assign y_valid = valid_q;

`ifdef DEMUX1TO4_STATS_EN
    logic [CNT_W-1:0] cnt_q [4];

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (drain[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_stat
        assign stat_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_demux1to4_16bit_stream.sv
// tb/tb_demux1to4_16bit_stream.sv - directed self-checking bench for demux1to4_16bit_stream

module tb_demux1to4_16bit_stream;

    logic        clk;
    logic        rst_n;
    logic [15:0] x;
    logic [1:0]  sel;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] y0, y1, y2, y3;
    logic [3:0]  y_valid;
    logic [3:0]  y_ready;
    logic [31:0] stat_cnt;

    int total = 0;
    int bad   = 0;

    demux1to4_16bit_stream #(.WIDTH(16), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .sel      (sel),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .stat_cnt (stat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] s);
        x       = d;
        sel     = s;
        x_valid = 1'b1;
        #1;
        chk("send_x_ready", {31'd0, x_ready}, 32'd1);
        tick();
        x_valid = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        x       = 16'h0000;
        sel     = 2'd0;
        x_valid = 1'b0;
        y_ready = 4'b0000;
        #12;
        chk("rst_y_valid", {28'd0, y_valid}, 32'd0);
        chk("rst_y0", {16'd0, y0}, 32'd0);
        chk("rst_y3", {16'd0, y3}, 32'd0);
        chk("rst_stat", stat_cnt, 32'd0);
        chk("rst_x_ready", {31'd0, x_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Routing: consumers always ready, one word per cycle to each channel.
        y_ready = 4'b1111;
        x = 16'h1234; sel = 2'd0; x_valid = 1'b1; #1;
        chk("route_rdy0", {31'd0, x_ready}, 32'd1);
        tick();
        chk("route_y0", {16'd0, y0}, 32'h1234);
        chk("route_v0", {28'd0, y_valid}, 32'b0001);
        x = 16'h5678; sel = 2'd1; #1;
        chk("route_rdy1", {31'd0, x_ready}, 32'd1);
        tick();
        chk("route_y1", {16'd0, y1}, 32'h5678);
        chk("route_v1", {28'd0, y_valid}, 32'b0010);
        x = 16'h9abc; sel = 2'd2; #1;
        chk("route_rdy2", {31'd0, x_ready}, 32'd1);
        tick();
        chk("route_y2", {16'd0, y2}, 32'h9abc);
        chk("route_v2", {28'd0, y_valid}, 32'b0100);
        x = 16'hdef0; sel = 2'd3; #1;
        chk("route_rdy3", {31'd0, x_ready}, 32'd1);
        tick();
        chk("route_y3", {16'd0, y3}, 32'hdef0);
        chk("route_v3", {28'd0, y_valid}, 32'b1000);
        x_valid = 1'b0;
        tick();
        chk("route_empty", {28'd0, y_valid}, 32'd0);
`ifdef DEMUX1TO4_STATS_EN
        chk("route_stat", stat_cnt, 32'h01010101);
`else
        chk("route_stat", stat_cnt, 32'd0);
`endif

        // Backpressure on channel 2, then drain+accept on one edge.
        y_ready = 4'b1011;
        send(16'hAAAA, 2'd2);
        chk("bp_v", {28'd0, y_valid}, 32'b0100);
        chk("bp_y2a", {16'd0, y2}, 32'hAAAA);
        x = 16'hBBBB; sel = 2'd2; x_valid = 1'b1; #1;
        chk("bp_not_ready", {31'd0, x_ready}, 32'd0);
        tick();
        chk("bp_y2_hold", {16'd0, y2}, 32'hAAAA);
        chk("bp_v_hold", {28'd0, y_valid}, 32'b0100);
        chk("bp_still_not_ready", {31'd0, x_ready}, 32'd0);
        y_ready = 4'b1111; #1;
        chk("bp_ready_up", {31'd0, x_ready}, 32'd1);
        tick();
        y_ready = 4'b1011;
        x_valid = 1'b0;
        chk("bp_v_stay", {28'd0, y_valid}, 32'b0100);
        chk("bp_y2b", {16'd0, y2}, 32'hBBBB);

        // Independence: channel 1 stalled while channel 3 is served.
        y_ready = 4'b0100;
        tick();
        chk("ind_ch2_drained", {28'd0, y_valid}, 32'd0);
        y_ready = 4'b0000;
        send(16'h1111, 2'd1);
        sel = 2'd1; #1;
        chk("ind_sel1_busy", {31'd0, x_ready}, 32'd0);
        sel = 2'd3; #1;
        chk("ind_sel3_free", {31'd0, x_ready}, 32'd1);
        send(16'h0F0F, 2'd3);
        chk("ind_y1", {16'd0, y1}, 32'h1111);
        chk("ind_y3", {16'd0, y3}, 32'h0F0F);
        chk("ind_v", {28'd0, y_valid}, 32'b1010);

        // Simultaneous drains of all four channels.
        send(16'h2222, 2'd0);
        send(16'h3333, 2'd2);
        chk("sim_full", {28'd0, y_valid}, 32'b1111);
        y_ready = 4'b1111;
        tick();
        y_ready = 4'b0000;
        chk("sim_v", {28'd0, y_valid}, 32'd0);
        chk("sim_y0", {16'd0, y0}, 32'h2222);
        chk("sim_y1", {16'd0, y1}, 32'h1111);
        chk("sim_y2", {16'd0, y2}, 32'h3333);
        chk("sim_y3", {16'd0, y3}, 32'h0F0F);

        // Asynchronous reset between edges with channels 0 and 3 full.
        send(16'h4444, 2'd0);
        send(16'h5555, 2'd3);
        chk("ar_full", {28'd0, y_valid}, 32'b1001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_v", {28'd0, y_valid}, 32'd0);
        chk("ar_y0", {16'd0, y0}, 32'd0);
        chk("ar_y3", {16'd0, y3}, 32'd0);
        chk("ar_stat", stat_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Stats: 300 back-to-back words to channel 0.
        y_ready = 4'b0001;
        sel     = 2'd0;
        x_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            x = 16'(i);
            tick();
        end
        x_valid = 1'b0;
        tick();
        chk("st_y0_last", {16'd0, y0}, 32'd299);
        chk("st_v", {28'd0, y_valid}, 32'd0);
`ifdef DEMUX1TO4_STATS_EN
        chk("st_cnt", stat_cnt, 32'h000000FF);
`else
        chk("st_cnt", stat_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
